// File: rtl/sseg_page_ctrl.sv
// sseg_page_ctrl: shares one 4-digit seven-segment word between NREQ requesters.
// Pages rotate round-robin every DWELL cycles or hold a pinned slot; the selected
// value is encoded one nibble per cycle and committed to sseg_s in one step.
//
// state | meaning
// IDLE  | wait for a rotate / refresh / first-write request
// LOAD  | latch the selected slot (or blank) into the work register
// ENC0  | encode nibble 0 (rightmost digit)
// ENC1  | encode nibble 1
// ENC2  | encode nibble 2
// ENC3  | encode nibble 3 (leftmost digit)
// OUT   | commit staged word and page index, pulse upd_pulse
module sseg_page_ctrl #(
    parameter int          NREQ  = 4,
    parameter logic [23:0] DWELL = 24'd5000000,
    parameter bit          LZB   = 1'b1
) (
    input  logic                 clk_s,
    input  logic                 rst_s,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 pin_en,
    input  logic [1:0]           pin_idx,
    output logic [31:0]          sseg_s,
    output logic [1:0]           page_idx,
    output logic                 upd_pulse
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ENC0, S_ENC1, S_ENC2, S_ENC3, S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           cnt_q, cnt_d;
    logic [NREQ-1:0][15:0] slot_q, slot_d;
    logic [NREQ-1:0]       vld_q, vld_d;
    logic                  req_q, req_d;     // an event (or pended event) awaits IDLE
    logic                  rot_q, rot_d;     // that request includes a rotate/first write
    logic [1:0]            tgt_q, tgt_d;
    logic                  blank_q, blank_d;
    logic [15:0]           work_q, work_d;
    logic [31:0]           enc_q, enc_d;
    logic [31:0]           sseg_q, sseg_d;
    logic [1:0]            page_q, page_d;
    logic                  upd_q, upd_d;

    logic [NREQ-1:0]       xfer;
    logic                  rot_evt, refresh, first_wr, leave, found;
    logic [3:0]            vld_x;
    logic [3:0][15:0]      slot_x;
    logic [1:0]            cand, k;
    logic [15:0]           upper;
    logic [7:0]            seg;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] r;
        r = 8'hFF;
        case (n)
            4'h0: r = 8'hC0;  4'h1: r = 8'hF9;  4'h2: r = 8'hA4;  4'h3: r = 8'hB0;
            4'h4: r = 8'h99;  4'h5: r = 8'h92;  4'h6: r = 8'h82;  4'h7: r = 8'hF8;
            4'h8: r = 8'h80;  4'h9: r = 8'h90;  4'hA: r = 8'h88;  4'hB: r = 8'h83;
            4'hC: r = 8'hC6;  4'hD: r = 8'hA1;  4'hE: r = 8'h86;  4'hF: r = 8'h8E;
        endcase
        return r;
    endfunction

    // Only the slot being shown is back-pressured while its page is being built.
    always_comb begin
        req_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (state_q != S_IDLE && tgt_q == 2'(i)) req_ready[i] = 1'b0;
        end
    end

    // Slot capture, dwell timer, event/pend tracking and the page-build FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        slot_d  = slot_q;
        vld_d   = vld_q;
        req_d   = req_q;
        rot_d   = rot_q;
        tgt_d   = tgt_q;
        blank_d = blank_q;
        work_d  = work_q;
        enc_d   = enc_q;
        sseg_d  = sseg_q;
        page_d  = page_q;
        upd_d   = 1'b0;
        refresh = 1'b0;
        found   = 1'b0;
        cand    = '0;
        k       = '0;
        upper   = '0;
        seg     = 8'hFF;
        vld_x   = '0;
        slot_x  = '0;

        xfer     = req_valid & req_ready;
        rot_evt  = (cnt_q == DWELL - 24'd1);
        first_wr = (|xfer) && (vld_q == '0);
        leave    = (state_q == S_IDLE) && req_q;

        if (rot_evt) cnt_d = '0;

        for (int i = 0; i < NREQ; i++) begin
            vld_x[i]  = vld_q[i];
            slot_x[i] = slot_q[i];
            if (xfer[i]) begin
                slot_d[i] = req_data[16*i +: 16];
                vld_d[i]  = 1'b1;
                if (page_q == 2'(i)) refresh = 1'b1;
            end
        end

        // An event arriving while busy (or in the cycle IDLE is left) stays in req_q
        // and is picked up on the next return to IDLE.
        if (leave) begin
            req_d = 1'b0;
            rot_d = 1'b0;
        end
        if (rot_evt || refresh || first_wr) begin
            req_d = 1'b1;
            if (rot_evt || first_wr) rot_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (leave) begin
                    state_d = S_LOAD;
                    tgt_d   = page_q;
                    if (pin_en) begin
                        tgt_d = pin_idx;
                    end else if (rot_q) begin
                        // page_idx itself is the last candidate of the scan
                        for (int j = 1; j <= NREQ; j++) begin
                            cand = 2'((int'(page_q) + j) % NREQ);
                            if (!found && vld_x[cand]) begin
                                found = 1'b1;
                                tgt_d = cand;
                            end
                        end
                    end
                end
            end
            S_LOAD: begin
                work_d  = slot_x[tgt_q];
                blank_d = !vld_x[tgt_q];
                state_d = S_ENC0;
            end
            S_ENC0, S_ENC1, S_ENC2, S_ENC3: begin
                case (state_q)
                    S_ENC0:  begin k = 2'd0; state_d = S_ENC1; end
                    S_ENC1:  begin k = 2'd1; state_d = S_ENC2; end
                    S_ENC2:  begin k = 2'd2; state_d = S_ENC3; end
                    default: begin k = 2'd3; state_d = S_OUT;  end
                endcase
                upper = work_q >> {k, 2'b00};
                seg   = hex7(upper[3:0]);
                if (LZB && k != 2'd0 && upper == 16'd0) seg = 8'hFF;
                if (tgt_q == k) seg[7] = 1'b0;
                if (blank_q) seg = 8'hFF;
                enc_d[{k, 3'b000} +: 8] = seg;
            end
            S_OUT: begin
                sseg_d  = enc_q;
                page_d  = tgt_q;
                upd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset returns every output to its idle value at once.
    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            vld_q   <= '0;
            req_q   <= 1'b0;
            rot_q   <= 1'b0;
            tgt_q   <= '0;
            blank_q <= 1'b0;
            work_q  <= '0;
            enc_q   <= '1;
            sseg_q  <= '1;
            page_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            vld_q   <= vld_d;
            req_q   <= req_d;
            rot_q   <= rot_d;
            tgt_q   <= tgt_d;
            blank_q <= blank_d;
            work_q  <= work_d;
            enc_q   <= enc_d;
            sseg_q  <= sseg_d;
            page_q  <= page_d;
            upd_q   <= upd_d;
        end
    end

    assign sseg_s    = sseg_q;
    assign page_idx  = page_q;
    assign upd_pulse = upd_q;

endmodule

// File: tb/tb_sseg_page_ctrl.sv
// Bench for sseg_page_ctrl: two instances (leading-zero blanking on and off) share
// stimulus; a slot/page model predicts every page update from the display rules.
module tb_sseg_page_ctrl;

    localparam int DW = 40;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk_s = 1'b0;
    logic        rst_s = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic        pin_en = 1'b0;
    logic [1:0]  pin_idx = '0;
    logic [3:0]  rdy_a, rdy_b;
    logic [31:0] sseg_a, sseg_b;
    logic [1:0]  page_a, page_b;
    logic        upd_a, upd_b;

    int          cyc;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] m_slot [4];
    bit          m_vld [4];
    int          m_page = 0;
    bit          m_pin = 1'b0;
    int          m_pin_idx = 0;

    sseg_page_ctrl #(.NREQ(4), .DWELL(24'(DW)), .LZB(1'b1)) u_a (
        .clk_s(clk_s), .rst_s(rst_s), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_a), .pin_en(pin_en), .pin_idx(pin_idx), .sseg_s(sseg_a),
        .page_idx(page_a), .upd_pulse(upd_a));

    sseg_page_ctrl #(.NREQ(4), .DWELL(24'(DW)), .LZB(1'b0)) u_b (
        .clk_s(clk_s), .rst_s(rst_s), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_b), .pin_en(pin_en), .pin_idx(pin_idx), .sseg_s(sseg_b),
        .page_idx(page_b), .upd_pulse(upd_b));

    always #5 clk_s = ~clk_s;

    // clock edges since reset release; rotate events fall on multiples of DW
    always @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_exp(input logic [15:0] v, input int pg, input bit lzb,
                                            input bit blank);
        logic [31:0] r;
        logic [7:0]  b;
        int          top, nib;
        top = 0;
        for (int k = 0; k < 4; k++) if (((v >> (4 * k)) & 16'hF) != 0) top = k;
        for (int k = 0; k < 4; k++) begin
            nib = int'((v >> (4 * k)) & 16'hF);
            b = HEX[nib];
            if (lzb && k > top) b = 8'hFF;
            if (k == pg) b = b & 8'h7F;
            if (blank) b = 8'hFF;
            r[8*k +: 8] = b;
        end
        return r;
    endfunction

    // first valid slot after 'from' in cyclic order, 'from' itself last; -1 if none
    function automatic int scan_next(input int from);
        int r;
        r = -1;
        for (int j = 4; j >= 1; j--) if (m_vld[(from + j) % 4]) r = (from + j) % 4;
        return r;
    endfunction

    task automatic wait_mod(input int m);
        int n;
        n = 0;
        do begin
            @(negedge clk_s);
            n++;
        end while ((cyc % DW) != m && n < 200);
    endtask

    task automatic check_update(input string tag, input int ref_c, input int pg, input bit blank,
                                input logic [15:0] v, input int exp_lo);
        int         lo;
        bit         seen;
        logic [3:0] msk;
        lo   = 0;
        seen = 1'b0;
        msk  = 4'hF & ~(4'b0001 << pg);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_s);
            seen = upd_a;
            if (!seen && rdy_a == msk) lo++;
        end
        chk_eq({tag, " latency"}, 32'(cyc - ref_c), 32'd7);
        chk_eq({tag, " page"}, 32'(page_a), 32'(pg));
        chk_eq({tag, " sseg lzb1"}, sseg_a, enc_exp(v, pg, 1'b1, blank));
        chk_eq({tag, " sseg lzb0"}, sseg_b, enc_exp(v, pg, 1'b0, blank));
        chk_eq({tag, " ready busy cycles"}, 32'(lo), 32'(exp_lo));
        chk_eq({tag, " ready idle"}, 32'(rdy_a), 32'hF);
        m_page = pg;
        @(negedge clk_s);
        chk_eq({tag, " pulse width"}, 32'(upd_a), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        int seen, n;
        seen = 0;
        n = 0;
        do begin
            @(negedge clk_s);
            n++;
            if (upd_a) seen++;
        end while ((cyc % DW) != 38 && n < 60);
        chk_eq(tag, 32'(seen), 32'd0);
    endtask

    task automatic do_rotate();
        int pg;
        bit blank;
        wait_mod(0);
        if (m_pin) begin
            pg    = m_pin_idx;
            blank = !m_vld[pg];
        end else begin
            pg    = scan_next(m_page);
            blank = (pg < 0);
            if (blank) pg = m_page;
        end
        check_update("rotate", cyc, pg, blank, m_slot[pg], 6);
    endtask

    // transfer lands on the edge where cyc % DW becomes m
    task automatic write_slot(input int s, input logic [15:0] v, input int m, output bit first);
        wait_mod((m + DW - 1) % DW);
        req_valid = 4'b0001 << s;
        req_data  = '0;
        req_data[16*s +: 16] = v;
        chk_eq("ready before write", 32'(rdy_a[s]), 32'd1);
        @(negedge clk_s);
        req_valid = '0;
        first = !(m_vld[0] || m_vld[1] || m_vld[2] || m_vld[3]);
        m_slot[s] = v;
        m_vld[s]  = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = '0;
            m_vld[i]  = 1'b0;
        end
        m_page = 0;
        m_pin  = 1'b0;
    endtask

    initial begin
        bit          first;
        int          s, pg;
        logic [15:0] v;

        clear_model();
        repeat (3) @(negedge clk_s);
        chk_eq("reset sseg", sseg_a, 32'hFFFF_FFFF);
        chk_eq("reset page", 32'(page_a), 32'd0);
        chk_eq("reset ready", 32'(rdy_a), 32'hF);
        chk_eq("reset upd", 32'(upd_a), 32'd0);
        rst_s = 1'b1;

        do_rotate();
        write_slot(0, 16'h12AF, 11, first);
        check_update("first write", cyc, 0, 1'b0, 16'h12AF, 6);
        do_rotate();
        write_slot(0, 16'h0005, 11, first);
        check_update("lzb", cyc, 0, 1'b0, 16'h0005, 6);

        for (int r = 0; r < 8; r++) begin
            do_rotate();
            s = $urandom_range(0, 2);
            v = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) v = 16'h0000;
            write_slot(s, v, 11, first);
            if (s == m_page) check_update("refresh", cyc, s, 1'b0, v, 6);
            else check_quiet("no event on other slot");
        end
        do_rotate();
        do_rotate();

        m_pin = 1'b1;
        m_pin_idx = 3;
        pin_en = 1'b1;
        pin_idx = 2'd3;
        do_rotate();
        write_slot(3, 16'h0001, 11, first);
        check_update("pin refresh", cyc, 3, 1'b0, 16'h0001, 6);
        do_rotate();
        m_pin = 1'b0;
        pin_en = 1'b0;

        v = 16'($urandom);
        write_slot(m_page, v, 0, first);
        pg = scan_next(m_page);
        check_update("collision", cyc, pg, 1'b0, m_slot[pg], 6);

        v = 16'($urandom);
        write_slot(m_page, v, 37, first);
        check_update("pend refresh", cyc, m_page, 1'b0, v, 6);
        pg = scan_next(m_page);
        check_update("pend rotate", cyc - 1, pg, 1'b0, m_slot[pg], 5);

        do_rotate();
        write_slot(m_page, 16'hBEEF, 11, first);
        repeat (3) @(negedge clk_s);
        chk_eq("busy ready", 32'(rdy_a), 32'(4'hF & ~(4'b0001 << m_page)));
        rst_s = 1'b0;
        #1;
        chk_eq("midop reset sseg", sseg_a, 32'hFFFF_FFFF);
        chk_eq("midop reset page", 32'(page_a), 32'd0);
        chk_eq("midop reset ready", 32'(rdy_a), 32'hF);
        chk_eq("midop reset upd", 32'(upd_a), 32'd0);
        @(negedge clk_s);
        rst_s = 1'b1;
        clear_model();

        do_rotate();
        write_slot(2, 16'h0A50, 11, first);
        check_update("post reset first", cyc, scan_next(0), 1'b0, 16'h0A50, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
